// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the datapath mux selects, ALU op and write enables from the latched op/funct.
module mc_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic [1:0] alu_op,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExeR   = 4'd2,
    StWbR    = 4'd3,
    StExeOri = 4'd4,
    StExeLui = 4'd5,
    StWbI    = 4'd6,
    StMemAdr = 4'd7,
    StMemRd  = 4'd8,
    StMemWb  = 4'd9,
    StMemWr  = 4'd10,
    StBranch = 4'd11,
    StJump   = 4'd12,
    StJr     = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  localparam logic [WAIT_W-1:0] Limit = WAIT_W'(WAIT_LIMIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic              req_state, stall, timeout;

  assign req_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign stall     = req_state && !mem_ready;
  // Saturate so an unlimited wait never wraps back through zero.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + WAIT_W'(1);
  assign timeout   = (WAIT_LIMIT != 0) && stall && (cnt_inc == Limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q | timeout;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        state_d = StFetch;
        case (op)
          OpRtype: begin
            if (funct == FnAddu || funct == FnSubu) state_d = StExeR;
            else if (funct == FnJr)                 state_d = StJr;
          end
          OpOri:      state_d = StExeOri;
          OpLui:      state_d = StExeLui;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpJ, OpJal: state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StExeR:   state_d = StWbR;
      StExeOri: state_d = StWbI;
      StExeLui: state_d = StWbI;
      StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      default:  state_d = StFetch;
    endcase
    if (timeout) state_d = StFetch;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (timeout || state_d != state_q) cnt_d = '0;
    else if (stall)                     cnt_d = cnt_inc;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    reg_wr     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    ext_op     = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StExeR: begin
        alu_src_a = 2'b01;
        alu_op    = (funct == FnSubu) ? 2'b01 : 2'b00;
      end
      StWbR: begin
        reg_wr  = 1'b1;
        reg_dst = 2'b01;
      end
      StExeOri: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      StExeLui: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        ext_op    = 2'b10;
      end
      StWbI: reg_wr = 1'b1;
      StMemAdr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      StBranch: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_wr     = zero;
      end
      StJump: begin
        pc_wr  = 1'b1;
        pc_src = 2'b10;
        if (op == OpJal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      StJr: begin
        pc_wr  = 1'b1;
        pc_src = 2'b11;
      end
      default: ;
    endcase
    // State is already FETCH in reset; suppress its request and any writes.
    if (!reset_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      reg_wr  = 1'b0;
    end
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction table, hand-written timeout/reset sequences
// and random instruction streams checked against a per-instruction state-path model.
module tb_mc_ctrl;

  localparam int WaitLimit = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_wr, pc_wr, reg_wr, err;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op;
  logic [3:0] state;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_wr, pc_wr;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op;
  } ctl_t;

  typedef struct packed {
    logic [63:0] name;
    logic [5:0]  op, funct;
    logic        z;
    int          fst, mst, lat;
  } vec_t;

  ctl_t act;
  assign act = {mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_op, alu_op};

  int   tests = 0;
  int   fails = 0;
  logic err_m = 1'b0;

  mc_ctrl #(.WAIT_LIMIT(WaitLimit), .WAIT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_op(alu_op), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  // Control word each state must present, straight from the state table.
  function automatic ctl_t exp_ctl(input int st, input logic rdy, input logic z,
                                   input logic sub, input logic jal);
    ctl_t c = '0;
    case (st)
      0:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_wr = rdy; c.pc_wr = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 2'b01; c.alu_op = sub ? 2'b01 : 2'b00; end
      3:  begin c.reg_wr = 1; c.reg_dst = 2'b01; end
      4:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
      5:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.ext_op = 2'b10; end
      6:  c.reg_wr = 1;
      7:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.ext_op = 2'b01; end
      8:  begin c.mem_req = 1; c.iord = 1; end
      9:  begin c.reg_wr = 1; c.mem_to_reg = 2'b01; end
      10: begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
      11: begin c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_wr = z; end
      12: begin
        c.pc_wr = 1; c.pc_src = 2'b10;
        if (jal) begin c.reg_wr = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
      end
      13: begin c.pc_wr = 1; c.pc_src = 2'b11; end
      default: ;
    endcase
    return c;
  endfunction

  // One clock: drive mem_ready (random where it must be ignored), check mid-cycle.
  task automatic cyc(input logic [63:0] nm, input int st, input logic rdy,
                     input logic sub, input logic jal);
    ctl_t ec;
    mem_ready = (st == 0 || st == 8 || st == 10) ? rdy : 1'($urandom);
    ec = exp_ctl(st, rdy, zero, sub, jal);
    @(negedge clk);
    tests++;
    if ({state, err, act} !== {4'(st), err_m, ec}) begin
      fails++;
      $display("FAIL %s: got state=%0d err=%0b ctl=%h, required state=%0d err=%0b ctl=%h",
               nm, state, err, act, st, err_m, ec);
    end
    @(posedge clk);
    #1;
  endtask

  // A request state: nst stall cycles then ready, unless the wait limit cuts it short.
  task automatic mem_phase(input logic [63:0] nm, input int st, input int nst,
                           input logic sub, input logic jal, output bit abort, output int n);
    abort = 0;
    n = 0;
    for (int k = 0; k <= nst; k++) begin
      cyc(nm, st, k == nst, sub, jal);
      n++;
      if (k == nst) break;
      if (k + 1 == WaitLimit) begin
        err_m = 1'b1;
        abort = 1;
        break;
      end
    end
  endtask

  task automatic run_instr(input logic [63:0] nm, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fst, input int mst, output int cycles);
    int   path[$];
    logic sub, jal;
    bit   abort;
    int   n;
    cycles = 0;
    op = o;
    funct = f;
    zero = z;
    sub = (o == 6'h00 && f == 6'h23);
    jal = (o == 6'h03);
    case (o)
      6'h00: begin
        if (f == 6'h21 || f == 6'h23) path = '{2, 3};
        else if (f == 6'h08)          path = '{13};
      end
      6'h0d:        path = '{4, 6};
      6'h0f:        path = '{5, 6};
      6'h23:        path = '{7, 8, 9};
      6'h2b:        path = '{7, 10};
      6'h04:        path = '{11};
      6'h02, 6'h03: path = '{12};
      default: ;
    endcase
    mem_phase(nm, 0, fst, sub, jal, abort, n);
    cycles += n;
    if (abort) return;
    cyc(nm, 1, 1'b0, sub, jal);
    cycles++;
    foreach (path[i]) begin
      if (path[i] == 8 || path[i] == 10) begin
        mem_phase(nm, path[i], mst, sub, jal, abort, n);
        cycles += n;
        if (abort) return;
      end else begin
        cyc(nm, path[i], 1'b0, sub, jal);
        cycles++;
      end
    end
  endtask

  vec_t vecs[14];
  logic [15:0] pool[12];

  initial begin
    int   n;
    bit   abort;
    int   idx;
    logic [5:0] ro, rf;

    vecs[0]  = '{"addu",  6'h00, 6'h21, 1'b0, 0, 0, 4};
    vecs[1]  = '{"subu",  6'h00, 6'h23, 1'b0, 1, 0, 5};
    vecs[2]  = '{"ori",   6'h0d, 6'h15, 1'b1, 0, 0, 4};
    vecs[3]  = '{"lui",   6'h0f, 6'h00, 1'b0, 2, 0, 6};
    vecs[4]  = '{"lw_st3", 6'h23, 6'h00, 1'b0, 0, 3, 8};
    vecs[5]  = '{"lw",    6'h23, 6'h3f, 1'b1, 0, 0, 5};
    vecs[6]  = '{"sw",    6'h2b, 6'h00, 1'b0, 0, 1, 5};
    vecs[7]  = '{"beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 3};
    vecs[8]  = '{"beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, 3};
    vecs[9]  = '{"j",     6'h02, 6'h00, 1'b0, 0, 0, 3};
    vecs[10] = '{"jal",   6'h03, 6'h00, 1'b1, 0, 0, 3};
    vecs[11] = '{"jr",    6'h00, 6'h08, 1'b0, 0, 0, 3};
    vecs[12] = '{"op3f",  6'h3f, 6'h21, 1'b0, 0, 0, 2};
    vecs[13] = '{"rnop",  6'h00, 6'h00, 1'b0, 1, 0, 3};

    pool = '{16'h0021, 16'h0023, 16'h0008, 16'h0d00, 16'h0f00, 16'h2300,
             16'h2b00, 16'h0400, 16'h0200, 16'h0300, 16'h3f00, 16'h0000};

    reset_n   = 1'b0;
    op        = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({state, err, mem_req, mem_we, ir_wr, pc_wr, reg_wr} !== 11'b0) begin
      fails++;
      $display("FAIL reset: got state=%0d err=%0b req=%0b we=%0b ir=%0b pc=%0b reg=%0b, required all 0",
               state, err, mem_req, mem_we, ir_wr, pc_wr, reg_wr);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].z, vecs[i].fst, vecs[i].mst, n);
      tests++;
      if (n != vecs[i].lat) begin
        fails++;
        $display("FAIL %s latency: got %0d cycles, required %0d", vecs[i].name, n, vecs[i].lat);
      end
    end

    // Fetch never answered: the wait limit must abandon it and raise err.
    mem_phase("fetch_to", 0, 10, 1'b0, 1'b0, abort, n);
    tests++;
    if (!abort || n != WaitLimit) begin
      fails++;
      $display("FAIL fetch_to: got abort=%0b after %0d cycles, required abort=1 after %0d",
               abort, n, WaitLimit);
    end

    // Reset in the middle of a stalled store.
    op = 6'h2b;
    funct = 6'h00;
    cyc("rst_sw", 0, 1'b1, 1'b0, 1'b0);
    cyc("rst_sw", 1, 1'b0, 1'b0, 1'b0);
    cyc("rst_sw", 7, 1'b0, 1'b0, 1'b0);
    cyc("rst_sw", 10, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({state, err, mem_req, mem_we, ir_wr, pc_wr, reg_wr} !== 11'b0) begin
      fails++;
      $display("FAIL rst_mid: got state=%0d err=%0b req=%0b we=%0b ir=%0b pc=%0b reg=%0b, required all 0",
               state, err, mem_req, mem_we, ir_wr, pc_wr, reg_wr);
    end
    err_m = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_instr("post_rst", 6'h00, 6'h21, 1'b0, 0, 0, n);
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL post_rst latency: got %0d cycles, required 4", n);
    end

    for (int t = 0; t < 300; t++) begin
      int fs, ms;
      idx = $urandom_range(11, 0);
      ro = pool[idx][13:8];
      rf = (ro == 6'h00) ? pool[idx][5:0] : 6'($urandom);
      fs = ($urandom_range(7, 0) == 0) ? $urandom_range(6, 4) : $urandom_range(2, 0);
      ms = ($urandom_range(7, 0) == 0) ? $urandom_range(6, 4) : $urandom_range(3, 0);
      run_instr("random", ro, rf, 1'($urandom), fs, ms, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
